// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Parametrised UART transmit framer. Accepts a parallel word over a
//   valid/ready handshake and serialises it as: start bit, DATA_W data bits
//   (LSB first), optional even/odd parity bit, then one or two stop bits.
//   Each bit is held for CLKS_PER_BIT clocks.
//
// Parameters
//   DATA_W        data bits per frame (5..9)
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   tx_data     word to send, sampled on accept
//   tx_valid    word available
//   tx_ready    framer idle and able to accept (combinational from state)
//   parity_en   1 = insert parity bit, sampled on accept
//   parity_odd  1 = odd parity, 0 = even, sampled on accept
//   stop2       1 = two stop bits, sampled on accept
//   tx_out      registered serial line, idles high
//   busy        frame in progress (= !tx_ready)
//   frame_done  one-clock pulse after the last stop bit completes
module uart_tx_framer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state;
  logic [BW-1:0]     r_baud;
  logic [IW-1:0]     r_bit_idx;
  logic              r_stop_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_en;
  logic              r_par_bit;
  logic              r_stop2;
  logic              r_tx_out;
  logic              r_frame_done;

  logic              w_accept;
  logic              w_bit_end;

  assign tx_ready   = (r_state == S_IDLE);
  assign busy       = ~tx_ready;
  assign tx_out     = r_tx_out;
  assign frame_done = r_frame_done;

  assign w_accept  = tx_valid && tx_ready;
  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit_idx    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_bit    <= 1'b0;
      r_stop2      <= 1'b0;
      r_tx_out     <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Line drops on the accept edge itself; parity is computed from
            // the word here because the shift register is consumed later.
            r_state    <= S_START;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= tx_data;
            r_par_en   <= parity_en;
            r_par_bit  <= (^tx_data) ^ parity_odd;
            r_stop2    <= stop2;
            r_tx_out   <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state  <= S_DATA;
            r_tx_out <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == IDX_LAST) begin
              if (r_par_en) begin
                r_state  <= S_PARITY;
                r_tx_out <= r_par_bit;
              end else begin
                r_state  <= S_STOP;
                r_tx_out <= 1'b1;
              end
            end else begin
              // r_shift[0] is always the bit currently on the line.
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx_out  <= r_shift[1];
            end
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_state  <= S_STOP;
            r_tx_out <= 1'b1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_state      <= S_IDLE;
              r_frame_done <= 1'b1;
            end
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
//   Scoreboard bench for uart_tx_framer (DATA_W=8, CLKS_PER_BIT=4).
//   Stimulus pushes the hand-written expected line sequence of each frame
//   into a queue; an independent monitor detects each start bit, pops the
//   expectation and checks every clock of the frame plus the frame_done cycle.
module tb_uart_tx_framer;

  localparam int C = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  uart_tx_framer #(
    .DATA_W      (8),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .stop2     (stop2),
    .tx_out    (tx_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;   // bits[k] = k-th line bit of the frame
    int          nbits;
    bit          b2b;    // must start exactly 1 clock after previous frame_done
    bit          abort;  // frame is expected to be cut short by reset
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   last_acc = -1;
  bit   mon_busy = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && tx_valid && tx_ready) last_acc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: detects a falling line, pops the expectation, checks each clock.
  initial begin
    exp_t e;
    logic prev;
    int   done_cyc;
    bit   aborted;
    logic req_bit;
    prev     = 1'b1;
    done_cyc = -100;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
        continue;
      end
      if (prev && !tx_out) begin
        mon_busy = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("start_on_accept_edge", cyc, last_acc);
          if (e.b2b) chk("b2b_gap", cyc - done_cyc, 1);
          aborted = 1'b0;
          for (int n = 0; n < e.nbits * C; n++) begin
            if (n > 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            req_bit = e.bits[n / C];
            n_vec++;
            if (tx_out !== req_bit || tx_ready !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
              n_miss++;
              $display("FAIL frame_clk%0d: got out=%b rdy=%b busy=%b done=%b expected out=%b rdy=0 busy=1 done=0",
                       n, tx_out, tx_ready, busy, frame_done, req_bit);
            end
          end
          if (!aborted) begin
            @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
            end else begin
              chk("frame_done_pulse", {tx_out, tx_ready, busy, frame_done}, 4'b1101);
              done_cyc = cyc;
            end
          end
          chk("abort_expected", aborted, e.abort);
        end
        mon_busy = 1'b0;
        prev = 1'b1;
      end else begin
        prev = tx_out;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic po, input logic s2,
                      input bit keep, input string bits, input bit b2b, input bit abrt);
    exp_t e;
    int   n;
    e.bits  = '0;
    e.nbits = bits.len();
    for (int k = 0; k < bits.len(); k++) e.bits[k] = (bits[k] == "1");
    e.b2b   = b2b;
    e.abort = abrt;
    q.push_back(e);
    @(negedge clk);
    tx_data    = d;
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
    tx_valid   = 1'b1;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 32'd1, 32'd0);
      tx_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      if (!keep) tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || mon_busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {31'd0, (q.size() == 0 && !mon_busy)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tx_out", tx_out, 1);

    // 0xA5, no parity, one stop: 10 bits, 40 clocks
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "0101001011", 1'b0, 1'b0);
    wait_idle();

    // 0x07 even parity -> parity 1 ; odd -> parity 0 ; 44 clocks
    send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, "01110000011", 1'b0, 1'b0);
    wait_idle();
    send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, "01110000001", 1'b0, 1'b0);
    wait_idle();

    // 0x00, two stop bits: 11 bits, 44 clocks
    send(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "00000000011", 1'b0, 1'b0);
    wait_idle();

    // back-to-back 0x55 then 0xAA with tx_valid held high
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, "0101010101", 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, "0010101011", 1'b1, 1'b0);
    wait_idle();

    // 0x96 even parity (bit 0), inputs disturbed during data bit 3
    send(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, "00110100101", 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    tx_data    = 8'h00;
    parity_en  = 1'b0;
    parity_odd = 1'b1;
    stop2      = 1'b1;
    wait_idle();
    parity_odd = 1'b0;
    stop2      = 1'b0;

    // 0xFF aborted by reset during data bit 4
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "0111111111", 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_out", tx_out, 1);
    chk("async_rst_ready", tx_ready, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", frame_done, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_idle();

    // clean frame after reset: 0x3C
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "0001111001", 1'b0, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("final_idle_line", tx_out, 1);
    chk("final_ready", tx_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
